mux_rr_arbiter: RTL and testbench
=================================

// Module: mux_rr_arbiter
// PURPOSE
//  Round-robin scheduler for the shared 16:1 bit-select mux: N_REQ requesters contend for the single mux output.
//  Arbitrates the requests, drives the mux select code plus a one-hot grant, and bounds each tenure to HOLD_MAX cycles.
//  Sits directly in front of the mux; sel connects to the mux select and rstn is shared with it.
// PARAMETERS
//  N_REQ     16  number of requesters / mux inputs (power of two)
//  SEL_W     4   select width, $clog2(N_REQ)
//  HOLD_MAX  8   max consecutive cycles one requester may own the mux (>=1)
//  HOLD_W    4   hold counter width, $clog2(HOLD_MAX)+1
// PORTS
//  clk          in   1      rising-edge clock
//  rstn         in   1      reset: synchronous, active-low
//  en           in   1      arbitration enable; low forces release and blocks new grants
//  req          in   N_REQ  per-requester request, level, held until served
//  mask         in   N_REQ  1 = requester ineligible (masked this cycle)
//  sel          out  SEL_W  registered mux select = index of current owner
//  grant        out  N_REQ  registered one-hot grant, all-zero when idle
//  grant_valid  out  1      registered: sel/grant denote a live owner
//  switch_p     out  1      1-cycle pulse: ownership started or changed this cycle
// BEHAVIOUR
//  Reset (rstn=0 at posedge): sel=0, grant=0, grant_valid=0, switch_p=0, ptr=0, hold_cnt=0, state=IDLE.
//   Mid-tenure reset aborts the grant at that edge; no release bookkeeping is kept.
//  elig = req & ~mask & {N_REQ{en}}; pick = first set bit of elig searching ptr, ptr+1, ..., wrapping N_REQ-1 -> 0.
//  FSM, 2 states:
//   IDLE: if |elig -> sel=pick, grant=1<<pick, grant_valid=1, switch_p=1, hold_cnt=0, -> OWN.
//         Else outputs stay at idle values. Latency: req high at edge k -> grant_valid high after edge k+1.
//   OWN:  hold_cnt++ each cycle; release when any of: !req[sel], mask[sel], !en, hold_cnt==HOLD_MAX-1.
//         Release sets ptr=(sel+1) mod N_REQ (15 wraps to 0); pick is re-evaluated from the new ptr the same cycle.
//          if |elig (the current owner is included only if still eligible, at lowest priority)
//            -> regrant with no bubble: update sel/grant, hold_cnt=0, switch_p=1, grant_valid stays 1.
//          else -> IDLE next edge: grant=0, grant_valid=0, sel holds last value.
//  Simultaneous release causes (e.g. req drop plus hold expiry) count as one release.
//  Single persistent requester with hold expiry: regranted to itself; switch_p pulses, hold_cnt restarts.
//  mask/en changes take effect at the next edge; a masked owner is released exactly as if its req dropped.
//  Invariants: grant==(grant_valid ? 1<<sel : 0); at most one bit of grant set; switch_p implies grant_valid.
//  No requester waits more than (N_REQ-1)*HOLD_MAX cycles while it is continuously eligible.
// STRUCTURE
//  Package mux_arb_pkg: N_REQ, SEL_W, HOLD_MAX defaults; typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;
//   typedefs req_vec_t and sel_t.
//  Sub-module rr_pick (combinational): inputs elig and ptr; outputs any and idx.
//   Implemented as a rotate, then a priority encode, then an add-back of ptr mod N_REQ.
//  The top level holds the FSM, ptr, hold_cnt and the output registers.
// TESTING
//  1. rstn=0 for 2 cycles with req=16'hFFFF -> grant=0, grant_valid=0, sel=0 throughout; first grant is 1 cycle after rstn=1.
//  2. req=16'h0001 held, HOLD_MAX=8 -> sel=0 for 8 cycles; then switch_p pulses and sel=0 is regranted; grant_valid never drops.
//  3. req=16'h8001 held -> sel=0 (8 cycles), sel=15 (8 cycles), sel=0 again: 15->0 wrap, switch_p at each change.
//  4. Owner sel=3; drop req[3] in the same cycle req[5] rises (req=16'h0020) -> next edge sel=5 with no idle cycle.
//  5. Owner sel=2; set mask=16'h0004, req=16'h0004 only -> release; grant_valid=0 next edge; sel stays 2.
//  6. Owner sel=7; pulse rstn=0 for 1 cycle -> all outputs 0 at that edge; regrant from ptr=0 (req=16'h0081 -> sel=0).

Source files
------------

// File: rtl/mux_arb_pkg.sv
// rtl/mux_arb_pkg.sv - shared parameters and types for the round-robin mux arbiter
package mux_arb_pkg;

    localparam int N_REQ    = 16;
    localparam int SEL_W    = $clog2(N_REQ);
    localparam int HOLD_MAX = 8;

    typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first eligible index at or after ptr
module rr_pick #(
    parameter int N_REQ = mux_arb_pkg::N_REQ,
    parameter int SEL_W = mux_arb_pkg::SEL_W
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;

    // Rotate so that ptr lands at bit 0; SEL_W-bit arithmetic wraps mod N_REQ.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = elig[SEL_W'(i) + ptr];
        end
    end

    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
    end

    assign any = |elig;
    assign idx = ptr + off;

endmodule

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin owner scheduler with bounded tenure for the shared 16:1 mux
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ    = mux_arb_pkg::N_REQ,
    parameter int SEL_W    = $clog2(N_REQ),
    parameter int HOLD_MAX = mux_arb_pkg::HOLD_MAX,
    parameter int HOLD_W   = $clog2(HOLD_MAX) + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             switch_p
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             gv_q, gv_d;
    logic             sw_q, sw_d;

    logic [N_REQ-1:0] elig;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             rel;

    assign elig = req & ~mask & {N_REQ{en}};

    // While owning, the only pick that matters is the one taken on release,
    // which searches from just past the owner (owner itself at lowest priority).
    assign pick_ptr = (state_q == ARB_OWN) ? sel_q + SEL_W'(1) : ptr_q;

    rr_pick #(
        .N_REQ (N_REQ),
        .SEL_W (SEL_W)
    ) u_pick (
        .elig (elig),
        .ptr  (pick_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign rel = !req[sel_q] || mask[sel_q] || !en
               || (hold_q == HOLD_W'(HOLD_MAX - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        sw_d    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_d = '0;
                gv_d    = 1'b0;
                if (pick_any) begin
                    state_d = ARB_OWN;
                    sel_d   = pick_idx;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gv_d    = 1'b1;
                    sw_d    = 1'b1;
                    hold_d  = '0;
                end
            end
            ARB_OWN: begin
                if (rel) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        gv_d    = 1'b1;
                        sw_d    = 1'b1;
                        hold_d  = '0;
                    end else begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                        gv_d    = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ARB_IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            grant_q <= '0;
            gv_q    <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            sw_q    <= sw_d;
        end
    end

    assign sel         = sel_q;
    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign switch_p    = sw_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - scoreboard bench for mux_rr_arbiter with directed vectors
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic [15:0] req = '0;
    logic [15:0] mask = '0;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        grant_valid;
    logic        switch_p;

    typedef struct {
        string      name;
        logic [3:0] sel;
        logic       gv;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    mux_rr_arbiter dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .req         (req),
        .mask        (mask),
        .sel         (sel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .switch_p    (switch_p)
    );

    always #5 clk = ~clk;

    // One cycle: drive inputs ahead of the edge, queue what must appear after it.
    task automatic cyc(input string name, input logic r, input logic e,
                       input logic [15:0] rq, input logic [15:0] mk,
                       input logic gv, input logic [3:0] s, input logic sw);
        exp_t x;
        @(negedge clk);
        rstn = r;
        en   = e;
        req  = rq;
        mask = mk;
        x.name = name;
        x.sel  = s;
        x.gv   = gv;
        x.sw   = sw;
        exp_q.push_back(x);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t        x;
            logic [15:0] eg;
            x  = exp_q.pop_front();
            eg = x.gv ? (16'h0001 << x.sel) : 16'h0000;
            checks++;
            if (sel !== x.sel || grant !== eg || grant_valid !== x.gv || switch_p !== x.sw) begin
                errors++;
                $display("FAIL %s: got sel=%0d grant=%h gv=%b sw=%b, want sel=%0d grant=%h gv=%b sw=%b",
                         x.name, sel, grant, grant_valid, switch_p, x.sel, eg, x.gv, x.sw);
            end
        end
    end

    initial begin
        // reset held with all requesting; first grant one edge after release
        cyc("rst_hold0", 0, 1, 16'hFFFF, 16'h0, 0, 0, 0);
        cyc("rst_hold1", 0, 1, 16'hFFFF, 16'h0, 0, 0, 0);
        cyc("first_grant", 1, 1, 16'hFFFF, 16'h0, 1, 0, 1);
        cyc("drop_all", 1, 1, 16'h0000, 16'h0, 0, 0, 0);

        // single persistent requester: hold expiry regrants itself
        cyc("solo_grant", 1, 1, 16'h0001, 16'h0, 1, 0, 1);
        for (int i = 0; i < 7; i++) cyc("solo_hold", 1, 1, 16'h0001, 16'h0, 1, 0, 0);
        cyc("solo_regrant", 1, 1, 16'h0001, 16'h0, 1, 0, 1);
        for (int i = 0; i < 7; i++) cyc("solo_hold2", 1, 1, 16'h0001, 16'h0, 1, 0, 0);
        cyc("solo_regrant2", 1, 1, 16'h0001, 16'h0, 1, 0, 1);

        // 0 -> 15 -> 0 wrap
        cyc("wrap_rst", 0, 1, 16'h8001, 16'h0, 0, 0, 0);
        cyc("wrap_g0", 1, 1, 16'h8001, 16'h0, 1, 0, 1);
        for (int i = 0; i < 7; i++) cyc("wrap_h0", 1, 1, 16'h8001, 16'h0, 1, 0, 0);
        cyc("wrap_g15", 1, 1, 16'h8001, 16'h0, 1, 15, 1);
        for (int i = 0; i < 7; i++) cyc("wrap_h15", 1, 1, 16'h8001, 16'h0, 1, 15, 0);
        cyc("wrap_g0b", 1, 1, 16'h8001, 16'h0, 1, 0, 1);
        cyc("wrap_h0b", 1, 1, 16'h8001, 16'h0, 1, 0, 0);

        // owner 3 drops while 5 rises: no idle bubble
        cyc("hand_rst", 0, 1, 16'h0000, 16'h0, 0, 0, 0);
        cyc("hand_g3", 1, 1, 16'h0008, 16'h0, 1, 3, 1);
        cyc("hand_h3", 1, 1, 16'h0008, 16'h0, 1, 3, 0);
        cyc("hand_g5", 1, 1, 16'h0020, 16'h0, 1, 5, 1);
        cyc("hand_h5", 1, 1, 16'h0020, 16'h0, 1, 5, 0);

        // masked owner released, sel keeps last value
        cyc("mask_rst", 0, 1, 16'h0000, 16'h0, 0, 0, 0);
        cyc("mask_g2", 1, 1, 16'h0004, 16'h0, 1, 2, 1);
        cyc("mask_rel", 1, 1, 16'h0004, 16'h0004, 0, 2, 0);
        cyc("mask_idle", 1, 1, 16'h0004, 16'h0004, 0, 2, 0);
        cyc("mask_other", 1, 1, 16'h0006, 16'h0004, 1, 1, 1);

        // mid-tenure reset, then regrant from ptr=0
        cyc("mid_rst0", 0, 1, 16'h0000, 16'h0, 0, 0, 0);
        cyc("mid_g7", 1, 1, 16'h0080, 16'h0, 1, 7, 1);
        cyc("mid_h7", 1, 1, 16'h0080, 16'h0, 1, 7, 0);
        cyc("mid_rst", 0, 1, 16'h0080, 16'h0, 0, 0, 0);
        cyc("mid_g0", 1, 1, 16'h0081, 16'h0, 1, 0, 1);

        // en low forces release; ptr advanced past owner
        cyc("en_low", 1, 0, 16'h0081, 16'h0, 0, 0, 0);
        cyc("en_block", 1, 0, 16'h0081, 16'h0, 0, 0, 0);
        cyc("en_high", 1, 1, 16'h0081, 16'h0, 1, 7, 1);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
